nvram_hps_bridge: RTL and testbench

- Transfers the 256-byte NVRAM shadow image between the MiSTer HPS file channel and the X2212-style nvram shadow array.
- On host load it writes the shadow array, then pulses a recall so the game sees the restored high scores.
- On host save it first pulses a store, waits for completion, then streams the shadow bytes to the host.
- Sits directly upstream of the NonVolatileRam stage's store/recall/shadow port and holds off CPU NVRAM writes while a transfer runs.

---
 rtl/nvram_hps_bridge.sv | 147 ++++++++++++++
 tb/tb_nvram_hps_bridge.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nvram_hps_bridge.sv
`default_nettype none
// ============================================================================
// Module   : nvram_hps_bridge
// Purpose  : Moves the NVRAM shadow image between the HPS file channel and the
//            X2212-style shadow array (load -> recall, store -> upload).
// Options  : NVRAM_LOAD_CHECK_EN - recall only after a complete image load,
//            otherwise raise sticky load_err.
// Revision : 1.0 - initial release
// ============================================================================
module nvram_hps_bridge #(
  parameter int AW        = 8,
  parameter int STORE_TMO = 1023
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          dl_active,
  input  logic          dl_wr,
  input  logic [AW-1:0] dl_addr,
  input  logic [7:0]    dl_data,
  input  logic          ul_active,
  input  logic          ul_rd,
  input  logic [AW-1:0] ul_addr,
  output logic [7:0]    ul_data,
  output logic          ul_valid,
  output logic          sh_we,
  output logic [AW-1:0] sh_addr,
  output logic [7:0]    sh_din,
  input  logic [7:0]    sh_dout,
  output logic          store_req,
  input  logic          store_done,
  output logic          recall_req,
  output logic          cpu_hold,
  output logic          busy
`ifdef NVRAM_LOAD_CHECK_EN
  ,
  output logic          load_err
`endif
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_RECALL  = 3'd2,
    S_STORE   = 3'd3,
    S_WAIT_ST = 3'd4,
    S_UPLOAD  = 3'd5
  } state_t;

  localparam logic [AW+1:0] c_tmo_last = (AW+2)'(STORE_TMO - 1);
  localparam logic [AW:0]   c_full     = (AW+1)'(2**AW);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW+1:0] r_tmo;
  logic [AW:0]   r_byte_cnt;
  logic          r_rd_p1;
  logic          w_load_wr;
  logic          w_up_rd;
  logic          w_load_ok;
  logic          w_load_entry;

  assign w_load_wr    = (r_state == S_LOAD) && dl_wr;
  assign w_up_rd      = (r_state == S_UPLOAD) && ul_rd;
  assign w_load_entry = (r_state == S_IDLE) && (w_state_nxt == S_LOAD);

`ifdef NVRAM_LOAD_CHECK_EN
  assign w_load_ok = (r_byte_cnt == c_full);
`else
  assign w_load_ok = 1'b1;
`endif

  // Shadow port is a straight pass-through; the shadow registers it itself.
  assign sh_we   = w_load_wr;
  assign sh_addr = w_load_wr ? dl_addr : (w_up_rd ? ul_addr : '0);
  assign sh_din  = w_load_wr ? dl_data : 8'h00;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (dl_active)      w_state_nxt = S_LOAD;
        else if (ul_active) w_state_nxt = S_STORE;
      end
      S_LOAD: begin
        if (!dl_active) w_state_nxt = w_load_ok ? S_RECALL : S_IDLE;
      end
      S_RECALL: w_state_nxt = S_IDLE;
      S_STORE:  w_state_nxt = S_WAIT_ST;
      S_WAIT_ST: begin
        if (!ul_active)                               w_state_nxt = S_IDLE;
        else if (store_done || (r_tmo == c_tmo_last)) w_state_nxt = S_UPLOAD;
      end
      S_UPLOAD: begin
        // Stay until the last accepted read has left the shadow.
        if (!ul_active && !r_rd_p1) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_tmo      <= '0;
      r_byte_cnt <= '0;
      r_rd_p1    <= 1'b0;
      ul_data    <= 8'h00;
      ul_valid   <= 1'b0;
      store_req  <= 1'b0;
      recall_req <= 1'b0;
      cpu_hold   <= 1'b0;
      busy       <= 1'b0;
`ifdef NVRAM_LOAD_CHECK_EN
      load_err   <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      store_req  <= (w_state_nxt == S_STORE);
      recall_req <= (w_state_nxt == S_RECALL);
      cpu_hold   <= (w_state_nxt == S_LOAD) || (w_state_nxt == S_RECALL) ||
                    (w_state_nxt == S_STORE) || (w_state_nxt == S_WAIT_ST);
      busy       <= (w_state_nxt != S_IDLE);

      if (r_state == S_STORE)        r_tmo <= '0;
      else if (r_state == S_WAIT_ST) r_tmo <= r_tmo + (AW+2)'(1);

      if (w_load_entry)
        r_byte_cnt <= '0;
      else if (w_load_wr && (r_byte_cnt != c_full))
        r_byte_cnt <= r_byte_cnt + (AW+1)'(1);

      // Read pipeline: address out at +0, shadow data at +1, ul_data at +2.
      r_rd_p1  <= w_up_rd;
      ul_valid <= r_rd_p1;
      if (r_rd_p1) ul_data <= sh_dout;

`ifdef NVRAM_LOAD_CHECK_EN
      if (w_load_entry)
        load_err <= 1'b0;
      else if ((r_state == S_LOAD) && !dl_active && !w_load_ok)
        load_err <= 1'b1;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nvram_hps_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_nvram_hps_bridge
// Purpose  : Directed self-checking bench for nvram_hps_bridge with a
//            behavioural 1-cycle-read shadow array.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nvram_hps_bridge;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       dl_active = 1'b0, dl_wr = 1'b0;
  logic [7:0] dl_addr = 8'h00, dl_data = 8'h00;
  logic       ul_active = 1'b0, ul_rd = 1'b0;
  logic [7:0] ul_addr = 8'h00;
  logic [7:0] ul_data;
  logic       ul_valid, sh_we, store_req, recall_req, cpu_hold, busy;
  logic       store_done = 1'b0;
  logic [7:0] sh_addr, sh_din;
  logic [7:0] sh_dout = 8'h00;
`ifdef NVRAM_LOAD_CHECK_EN
  logic       load_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_we     = 0;
  int n_recall = 0;
  int n_store  = 0;
  int n_hold_bad = 0;
  logic [7:0] mem [256];
  logic [7:0] vq [$];
  int         vc [$];

  nvram_hps_bridge #(.AW(8), .STORE_TMO(1023)) dut (
    .clk(clk), .reset_n(reset_n),
    .dl_active(dl_active), .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data),
    .ul_active(ul_active), .ul_rd(ul_rd), .ul_addr(ul_addr),
    .ul_data(ul_data), .ul_valid(ul_valid),
    .sh_we(sh_we), .sh_addr(sh_addr), .sh_din(sh_din), .sh_dout(sh_dout),
    .store_req(store_req), .store_done(store_done), .recall_req(recall_req),
    .cpu_hold(cpu_hold), .busy(busy)
`ifdef NVRAM_LOAD_CHECK_EN
    , .load_err(load_err)
`endif
  );

  always #5 clk = ~clk;

  // Shadow array model: synchronous write, 1-cycle synchronous read.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (sh_we) mem[sh_addr] <= sh_din;
    sh_dout <= mem[sh_addr];
  end

  always @(negedge clk) begin
    if (sh_we) n_we <= n_we + 1;
    if (sh_we && !cpu_hold) n_hold_bad <= n_hold_bad + 1;
    if (recall_req) n_recall <= n_recall + 1;
    if (store_req) n_store <= n_store + 1;
    if (ul_valid) begin
      vq.push_back(ul_data);
      vc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_load(input int n, input logic [7:0] pat);
    dl_active = 1'b1;
    tick();
    for (int i = 0; i < n; i++) begin
      dl_wr   = 1'b1;
      dl_addr = 8'(i);
      dl_data = 8'(i) ^ pat;
      tick();
    end
    dl_wr     = 1'b0;
    dl_active = 1'b0;
    tick(3);
  endtask

  initial begin
    int we0, rc0, st0, errs, t0, el, q0;
    logic got_up;

    // Reset state
    tick(3);
    @(negedge clk);
    check("rst_store_req", store_req, 0);
    check("rst_recall_req", recall_req, 0);
    check("rst_cpu_hold", cpu_hold, 0);
    check("rst_busy", busy, 0);
    check("rst_ul_valid", ul_valid, 0);
    check("rst_sh_we", sh_we, 0);
    check("rst_ul_data", ul_data, 0);
    reset_n = 1'b1;
    tick(2);

    // Full load with data = addr ^ 5A
    we0 = n_we; rc0 = n_recall; st0 = n_store;
    do_load(256, 8'h5A);
    check("load_we_count", n_we - we0, 256);
    check("load_recall_count", n_recall - rc0, 1);
    check("load_store_count", n_store - st0, 0);
    check("load_hold_bad", n_hold_bad, 0);
    check("load_busy_after", busy, 0);
    check("load_hold_after", cpu_hold, 0);
    check("load_mem_00", mem[8'h00], 8'h5A);
    check("load_mem_7f", mem[8'h7F], 8'h25);
    check("load_mem_ff", mem[8'hFF], 8'hA5);
    errs = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== (8'(i) ^ 8'h5A)) errs++;
    check("load_mem_all", errs, 0);
`ifdef NVRAM_LOAD_CHECK_EN
    check("load_err_full", load_err, 0);
`endif

    // Preload shadow with ~addr through the load path, then save
    do_load(256, 8'hFF);
    we0 = n_we; st0 = n_store;
    vq.delete(); vc.delete();
    ul_active = 1'b1;
    tick(512);
    @(negedge clk);
    check("save_hold_waiting", cpu_hold, 1);
    check("save_store_once", n_store - st0, 1);
    store_done = 1'b1;
    tick();
    store_done = 1'b0;
    @(negedge clk);
    check("save_hold_upload", cpu_hold, 0);
    check("save_busy_upload", busy, 1);
    tick();
    begin
      int req_cyc [256];
      for (int i = 0; i < 256; i++) begin
        ul_rd = 1'b1; ul_addr = 8'(i); req_cyc[i] = cyc;
        tick();
      end
      ul_rd = 1'b0;
      tick(4);
      check("save_valid_count", vq.size(), 256);
      errs = 0;
      for (int i = 0; i < 256 && i < vq.size(); i++) begin
        check("save_ul_data", vq[i], 8'(i) ^ 8'hFF);
        if (vc[i] != req_cyc[i] + 2) errs++;
      end
      check("save_latency_errs", errs, 0);
    end
    check("save_no_we", n_we - we0, 0);
    ul_active = 1'b0;
    tick(3);
    check("save_busy_after", busy, 0);

    // Store timeout: store_done never arrives
    st0 = n_store;
    ul_active = 1'b1;
    t0 = cyc;
    got_up = 1'b0;
    el = 0;
    for (int k = 0; k < 1200 && !got_up; k++) begin
      tick();
      @(negedge clk);
      if (busy && !cpu_hold && (cyc - t0) > 2) begin
        got_up = 1'b1;
        el = cyc - t0;
      end
    end
    check("tmo_reached_upload", got_up, 1);
    check("tmo_window", (el >= 1023 && el <= 1027), 1);
    check("tmo_store_once", n_store - st0, 1);
    tick();
    we0 = n_we;
    dl_wr = 1'b1; dl_addr = 8'h03; dl_data = 8'h00;
    tick();
    dl_wr = 1'b0;
    q0 = vq.size();
    ul_rd = 1'b1; ul_addr = 8'h10;
    tick();
    ul_rd = 1'b0;
    tick(3);
    check("tmo_dl_wr_ignored", n_we - we0, 0);
    check("tmo_read_count", vq.size() - q0, 1);
    if (vq.size() > q0) check("tmo_read_data", vq[q0], 8'hEF);
    ul_active = 1'b0;
    tick(3);

    // Simultaneous rise: LOAD wins
    st0 = n_store; rc0 = n_recall;
    dl_active = 1'b1; ul_active = 1'b1;
    tick(2);
    @(negedge clk);
    check("simul_hold", cpu_hold, 1);
    dl_active = 1'b0; ul_active = 1'b0;
    tick(3);
    check("simul_no_store", n_store - st0, 0);
`ifdef NVRAM_LOAD_CHECK_EN
    check("simul_recall", n_recall - rc0, 0);
    check("simul_load_err", load_err, 1);
`else
    check("simul_recall", n_recall - rc0, 1);
`endif
    check("simul_busy_after", busy, 0);

    // ul_rd in IDLE is ignored
    q0 = vq.size();
    ul_rd = 1'b1; ul_addr = 8'h00;
    tick();
    ul_rd = 1'b0;
    tick(3);
    check("idle_rd_ignored", vq.size() - q0, 0);

    // Reset mid-load after 100 bytes
    rc0 = n_recall;
    dl_active = 1'b1;
    tick();
    for (int i = 0; i < 100; i++) begin
      dl_wr = 1'b1; dl_addr = 8'(i); dl_data = 8'(i) ^ 8'hA5;
      tick();
    end
    dl_wr = 1'b0; dl_active = 1'b0;
    reset_n = 1'b0;
    #1;
    check("rstmid_cpu_hold", cpu_hold, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_recall", recall_req, 0);
    check("rstmid_sh_we", sh_we, 0);
`ifdef NVRAM_LOAD_CHECK_EN
    check("rstmid_load_err", load_err, 0);
`endif
    tick(2);
    reset_n = 1'b1;
    tick(3);
    check("rstmid_no_recall", n_recall - rc0, 0);
    check("rstmid_mem_99", mem[99], 8'hC6);
    check("rstmid_mem_100", mem[100], 8'h9B);
    st0 = n_store;
    q0 = vq.size();
    ul_active = 1'b1;
    tick(10);
    store_done = 1'b1;
    tick();
    store_done = 1'b0;
    ul_rd = 1'b1; ul_addr = 8'd200;
    tick();
    ul_rd = 1'b0;
    tick(3);
    check("rstmid_save_store", n_store - st0, 1);
    check("rstmid_save_count", vq.size() - q0, 1);
    if (vq.size() > q0) check("rstmid_save_data", vq[q0], 8'h37);
    ul_active = 1'b0;
    tick(3);

`ifdef NVRAM_LOAD_CHECK_EN
    // Short load is refused, full load clears the error and recalls
    rc0 = n_recall;
    do_load(255, 8'h11);
    check("chk_short_recall", n_recall - rc0, 0);
    check("chk_short_err", load_err, 1);
    rc0 = n_recall;
    do_load(256, 8'h11);
    check("chk_full_recall", n_recall - rc0, 1);
    check("chk_full_err", load_err, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
